// File: rtl/serial_adder.sv
// Bit-serial adder: two WIDTH-bit operands plus carry-in are summed LSB-first,
// one bit per clock, through a single carry flip-flop behind valid/ready handshakes.
module serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready is high only in IDLE and out_valid only in DONE, so an
    // operation is never accepted in the same cycle a result is consumed.

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             bit_s;
    logic             bit_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        bit_s   = a_q[0] ^ b_q[0] ^ c_q;
        bit_c   = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    c_d     = carry_in;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                c_d   = bit_c;
                res_d = {bit_s, res_q[WIDTH-1:1]};
                // Visible outputs update only on the MSB step; c_q is then the carry into the MSB.
                if (cnt_q == LAST) begin
                    sum_d   = {bit_s, res_q[WIDTH-1:1]};
                    cout_d  = bit_c;
                    ovf_d   = c_q ^ bit_c;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder at WIDTH=8 and WIDTH=32.
module tb_serial_adder;

  localparam int N_RAND = 1000;
  localparam int W32    = 34;  // {overflow, carry_out, sum}

  logic clk;
  logic rst_n;

  // WIDTH=8 instance
  logic       in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0] op_a8, op_b8, sum8;
  logic       cin8, cout8, ovf8, busy8;
  logic [1:0] state8;

  // WIDTH=32 instance
  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] op_a32, op_b32, sum32;
  logic        cin32, cout32, ovf32, busy32;
  logic [1:0]  state32;

  int n_checks;
  int n_errors;
  logic [W32-1:0] exp_q[$];

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .op_a      (op_a8),
    .op_b      (op_b8),
    .carry_in  (cin8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .carry_out (cout8),
    .overflow  (ovf8),
    .busy      (busy8),
    .dbg_state (state8)
  );

  serial_adder #(.WIDTH(32)) u_dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .op_a      (op_a32),
    .op_b      (op_b32),
    .carry_in  (cin32),
    .out_valid (out_valid32),
    .out_ready (out_ready32),
    .sum       (sum32),
    .carry_out (cout32),
    .overflow  (ovf32),
    .busy      (busy32),
    .dbg_state (state32)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks (WIDTH=8)
  task automatic accept8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic cin);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready8 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, ":in_ready"}, 64'(in_ready8), 64'd1);
    in_valid8 = 1'b1;
    op_a8     = a;
    op_b8     = b;
    cin8      = cin;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    op_a8     = 8'($urandom);
    op_b8     = 8'($urandom);
    cin8      = 1'($urandom);
  endtask

  task automatic start8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] es, input logic ec, input logic eo);
    int lat;
    accept8(tag, a, b, cin);
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ":latency"}, 64'(lat), 64'd8);
    check({tag, ":sum"}, 64'(sum8), 64'(es));
    check({tag, ":cout"}, 64'(cout8), 64'(ec));
    check({tag, ":ovf"}, 64'(ovf8), 64'(eo));
  endtask

  task automatic consume8(input string tag);
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    check({tag, ":out_valid_drop"}, 64'(out_valid8), 64'd0);
    check({tag, ":in_ready_back"}, 64'(in_ready8), 64'd1);
  endtask

  initial begin
    int acc, rcv, cyc;
    logic [32:0]    full;
    logic [W32-1:0] exp_v;
    logic [W32-1:0] got_v;
    logic           eovf;

    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    in_valid8  = 1'b0; out_ready8  = 1'b0; op_a8  = '0; op_b8  = '0; cin8  = 1'b0;
    in_valid32 = 1'b0; out_ready32 = 1'b0; op_a32 = '0; op_b32 = '0; cin32 = 1'b0;
    repeat (3) @(negedge clk);

    check("rst:in_ready", 64'(in_ready8), 64'd1);
    check("rst:out_valid", 64'(out_valid8), 64'd0);
    check("rst:busy", 64'(busy8), 64'd0);
    check("rst:sum", 64'(sum8), 64'd0);
    check("rst:cout", 64'(cout8), 64'd0);
    check("rst:ovf", 64'(ovf8), 64'd0);
    check("rst:state", 64'(state8), 64'd0);
    rst_n = 1'b1;

    // basic additions
    start8("t1_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    consume8("t1");
    start8("t2_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    consume8("t2a");
    start8("t2_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    consume8("t2b");

    // subtraction via inverted op_b and carry_in=1
    start8("t3_5m3", 8'h05, 8'hFC, 1'b1, 8'h02, 1'b1, 1'b0);
    consume8("t3a");
    start8("t3_3m5", 8'h03, 8'hFA, 1'b1, 8'hFE, 1'b0, 1'b0);
    consume8("t3b");

    // backpressure in DONE with ignored in_valid pulses
    start8("t4", 8'h21, 8'h42, 1'b1, 8'h64, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid8 = 1'b1;
      op_a8     = 8'($urandom);
      op_b8     = 8'($urandom);
      cin8      = 1'($urandom);
      @(negedge clk);
      check("t4:hold_out_valid", 64'(out_valid8), 64'd1);
      check("t4:hold_sum", 64'(sum8), 64'h64);
      check("t4:hold_cout", 64'(cout8), 64'd0);
      check("t4:hold_in_ready", 64'(in_ready8), 64'd0);
      check("t4:hold_state", 64'(state8), 64'd2);
    end
    in_valid8 = 1'b0;
    consume8("t4");
    check("t4:idle_busy", 64'(busy8), 64'd0);
    check("t4:idle_sum_kept", 64'(sum8), 64'h64);

    // asynchronous reset mid-RUN
    accept8("t5_abort", 8'hAA, 8'h55, 1'b0);
    repeat (3) @(negedge clk);
    check("t5:busy_before", 64'(busy8), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5:rst_out_valid", 64'(out_valid8), 64'd0);
    check("t5:rst_in_ready", 64'(in_ready8), 64'd1);
    check("t5:rst_busy", 64'(busy8), 64'd0);
    check("t5:rst_sum", 64'(sum8), 64'd0);
    #1 rst_n = 1'b1;
    start8("t5_12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    consume8("t5");

    // WIDTH=32 randomised traffic with scoreboard
    acc = 0;
    rcv = 0;
    cyc = 0;
    while ((acc < N_RAND || rcv < N_RAND) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      in_valid32  = (acc < N_RAND) && ($urandom_range(0, 3) != 0);
      op_a32      = $urandom;
      op_b32      = $urandom;
      cin32       = 1'($urandom_range(0, 1));
      out_ready32 = ($urandom_range(0, 3) != 0);
      if (in_valid32 && in_ready32) begin
        full = {1'b0, op_a32} + {1'b0, op_b32} + {32'd0, cin32};
        eovf = (op_a32[31] == op_b32[31]) && (full[31] != op_a32[31]);
        exp_q.push_back({eovf, full});
        acc++;
      end
      if (out_valid32 && out_ready32) begin
        got_v = {ovf32, cout32, sum32};
        if (exp_q.size() == 0) begin
          check("t6:unexpected_result", 64'(got_v), 64'd0);
        end else begin
          exp_v = exp_q.pop_front();
          check("t6:result", 64'(got_v), 64'(exp_v));
        end
        rcv++;
      end
    end
    in_valid32  = 1'b0;
    out_ready32 = 1'b0;
    check("t6:accepted", 64'(acc), 64'(N_RAND));
    check("t6:received", 64'(rcv), 64'(N_RAND));
    check("t6:queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
